// File: rtl/press_classifier_if.sv
// rtl/press_classifier_if.sv - switch level in, press event pulses and press count out
interface press_classifier_if #(
  parameter int CNT_W = 8
);
  logic             SwOutDB1;
  logic             ShortPress;
  logic             LongPress;
  logic             DoubleClick;
  logic [CNT_W-1:0] PressCount;

  modport master (
    output SwOutDB1,
    input  ShortPress, LongPress, DoubleClick, PressCount
  );

  modport slave (
    input  SwOutDB1,
    output ShortPress, LongPress, DoubleClick, PressCount
  );
endinterface

// File: rtl/press_classifier.sv
// rtl/press_classifier.sv - classifies debounced presses as short, long or double-click
module press_classifier #(
  parameter int LONG_MS   = 500,
  parameter int DCLICK_MS = 250,
  parameter int TIMER_W   = 10,
  parameter int CNT_W     = 8
) (
  input logic               Clk1ms,
  input logic               Rst,
  press_classifier_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    PRESSED        = 3'd1,
    LONG_HELD      = 3'd2,
    WAIT_SECOND    = 3'd3,
    SECOND_PRESSED = 3'd4
  } state_t;

  localparam logic [TIMER_W-1:0] LONG_LAST   = TIMER_W'(LONG_MS - 1);
  localparam logic [TIMER_W-1:0] DCLICK_LAST = TIMER_W'(DCLICK_MS - 1);

  state_t             state, state_n;
  logic [TIMER_W-1:0] timer, timer_n;
  logic               prev;
  logic               level, rise, fall;
  logic               short_n, long_n, dbl_n;
  logic               short_q, long_q, dbl_q;
  logic [CNT_W-1:0]   count;

  assign level = bus.SwOutDB1;
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

  always_ff @(posedge Clk1ms or posedge Rst) begin
    if (Rst) begin
      state   <= IDLE;
      timer   <= '0;
      prev    <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      dbl_q   <= 1'b0;
      count   <= '0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      prev    <= level;
      short_q <= short_n;
      long_q  <= long_n;
      dbl_q   <= dbl_n;
      if (rise && (count != {CNT_W{1'b1}}))
        count <= count + CNT_W'(1);
    end
  end

  always_comb begin
    state_n = state;
    timer_n = timer;
    short_n = 1'b0;
    long_n  = 1'b0;
    dbl_n   = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_n = PRESSED;
          timer_n = TIMER_W'(1);
        end
      end
      PRESSED: begin
        if (level) begin
          if (timer == LONG_LAST) begin
            long_n  = 1'b1;
            state_n = LONG_HELD;
          end else begin
            timer_n = timer + TIMER_W'(1);
          end
        end else if (fall) begin
          state_n = WAIT_SECOND;
          timer_n = TIMER_W'(1);
        end
      end
      LONG_HELD: begin
        if (fall) state_n = IDLE;
      end
      // A high sample on the last allowed low edge still counts as the second press.
      WAIT_SECOND: begin
        if (level) begin
          dbl_n   = 1'b1;
          state_n = SECOND_PRESSED;
        end else if (timer == DCLICK_LAST) begin
          short_n = 1'b1;
          state_n = IDLE;
        end else begin
          timer_n = timer + TIMER_W'(1);
        end
      end
      SECOND_PRESSED: begin
        if (fall) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        timer_n = '0;
      end
    endcase
  end

  assign bus.ShortPress  = short_q;
  assign bus.LongPress   = long_q;
  assign bus.DoubleClick = dbl_q;
  assign bus.PressCount  = count;

endmodule
